// File: rtl/arb2_merge_pkg.sv
// rtl/arb2_merge_pkg.sv - shared constants and state encoding for arb2_merge
//
// Purpose: state encoding for the arbitration FSM and the default beat width.
// Ports:   none (package).

package arb2_merge_pkg;

   localparam int DEFAULT_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } state_e;

endpackage

// File: rtl/mux2e.sv
// rtl/mux2e.sv - two-way select over a [upper:lower] bit field
//
// Purpose: picks in1 when sel is high, otherwise in0.
// Ports:
//   sel  in   select, 1 chooses in1
//   in0  in   [upper:lower] candidate 0
//   in1  in   [upper:lower] candidate 1
//   out  out  [upper:lower] selected value

module mux2e #(
   parameter int upper = 32,
   parameter int lower = 0
) (
   input  logic               sel,
   input  logic [upper:lower] in0,
   input  logic [upper:lower] in1,
   output logic [upper:lower] out
);

   assign out = sel ? in1 : in0;

endmodule

// File: rtl/arb2_merge.sv
// rtl/arb2_merge.sv - two-input packet merger with round-robin arbitration
//
// Purpose: merges two valid/ready packet streams onto one registered output
//          stream. A grant is held from the first beat of a packet until its
//          last beat is accepted, so packets never interleave.
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   in0_valid/data/last/ready     source 0 stream
//   in1_valid/data/last/ready     source 1 stream
//   out_valid/data/last/src       registered output beat and its source index
//   out_ready                     downstream accept

module arb2_merge
   import arb2_merge_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in0_valid,
   input  logic [WIDTH-1:0] in0_data,
   input  logic             in0_last,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [WIDTH-1:0] in1_data,
   input  logic             in1_last,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             out_src,
   input  logic             out_ready
);

   state_e           state_q, state_d;
   logic             rr_q, rr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_last_q, out_last_d;
   logic             out_src_q, out_src_d;

   logic             grant;
   logic             grant_vld;
   logic             load;
   logic             xfer;
   logic [WIDTH:0]   sel_beat;

   // Grant is a pure function of registered state and the two valids.
   // With nothing valid in IDLE the select rests on the preferred source.
   always_comb begin
      grant     = rr_q;
      grant_vld = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in0_valid && in1_valid) begin
               grant_vld = 1'b1;
               grant     = rr_q;
            end else if (in0_valid) begin
               grant_vld = 1'b1;
               grant     = 1'b0;
            end else if (in1_valid) begin
               grant_vld = 1'b1;
               grant     = 1'b1;
            end
         end
         ST_LOCK0: begin
            grant_vld = 1'b1;
            grant     = 1'b0;
         end
         ST_LOCK1: begin
            grant_vld = 1'b1;
            grant     = 1'b1;
         end
         default: begin
            grant_vld = 1'b0;
            grant     = 1'b0;
         end
      endcase
   end

   // The output register can take a new beat when empty or draining now.
   assign load = !out_valid_q || out_ready;

   // reset_n gating keeps both readies low for the whole reset pulse.
   assign in0_ready = reset_n && load && grant_vld && !grant;
   assign in1_ready = reset_n && load && grant_vld &&  grant;

   assign xfer = grant ? (in1_valid && in1_ready) : (in0_valid && in0_ready);

   mux2e #(
      .upper (WIDTH),
      .lower (0)
   ) u_mux2e (
      .sel (grant),
      .in0 ({in0_last, in0_data}),
      .in1 ({in1_last, in1_data}),
      .out (sel_beat)
   );

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_src_d   = out_src_q;

      if (xfer) begin
         out_valid_d = 1'b1;
         out_data_d  = sel_beat[WIDTH-1:0];
         out_last_d  = sel_beat[WIDTH];
         out_src_d   = grant;
         if (sel_beat[WIDTH]) begin
            state_d = ST_IDLE;
            rr_d    = !grant;
         end else begin
            // In LOCKx grant already equals x, so this holds the lock.
            state_d = grant ? ST_LOCK1 : ST_LOCK0;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // An unreachable encoding grants nothing; recover to IDLE.
      if (state_q != ST_IDLE && state_q != ST_LOCK0 && state_q != ST_LOCK1) begin
         state_d = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rr_q        <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_src_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb2_merge.sv
// tb/tb_arb2_merge.sv - scoreboard bench for arb2_merge

module tb_arb2_merge;

   localparam int W = 32;

   typedef struct packed {
      logic         src;
      logic         last;
      logic [W-1:0] data;
   } beat_t;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         in0_valid, in0_last, in0_ready;
   logic [W-1:0] in0_data;
   logic         in1_valid, in1_last, in1_ready;
   logic [W-1:0] in1_data;
   logic         out_valid, out_last, out_src, out_ready;
   logic [W-1:0] out_data;

   int checks = 0;
   int errors = 0;

   beat_t sbq[$];
   beat_t logq[$];

   logic [1:0] m_state;
   logic       m_rr, m_ov;
   logic       m_gv, m_g, m_ld, m_r0, m_r1, m_xf, m_lst;
   beat_t      m_b;

   always #5 clk = ~clk;

   arb2_merge #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_last  (in0_last),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_last  (in1_last),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model: evaluated mid-cycle on settled inputs, advanced to the
   // state the design should hold after the coming rising edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         sbq.delete();
         m_state = 2'd0;
         m_rr    = 1'b0;
         m_ov    = 1'b0;
         chk("rst_in0_ready", in0_ready, 0);
         chk("rst_in1_ready", in1_ready, 0);
         chk("rst_out_valid", out_valid, 0);
      end else begin
         m_ld = !m_ov || out_ready;
         case (m_state)
            2'd0: begin
               m_gv = in0_valid || in1_valid;
               m_g  = (in0_valid && in1_valid) ? m_rr : in1_valid;
            end
            2'd1: begin m_gv = 1'b1; m_g = 1'b0; end
            default: begin m_gv = 1'b1; m_g = 1'b1; end
         endcase
         m_r0 = m_ld && m_gv && !m_g;
         m_r1 = m_ld && m_gv &&  m_g;
         chk("in0_ready", in0_ready, m_r0);
         chk("in1_ready", in1_ready, m_r1);
         chk("out_valid", out_valid, m_ov);

         if (m_ov) begin
            chk("sb_nonempty", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
               chk("out_data", out_data, sbq[0].data);
               chk("out_last", out_last, sbq[0].last);
               chk("out_src",  out_src,  sbq[0].src);
               if (out_ready) logq.push_back(sbq.pop_front());
            end
         end

         m_xf  = m_g ? (in1_valid && m_r1) : (in0_valid && m_r0);
         m_lst = m_g ? in1_last : in0_last;
         if (m_xf) begin
            m_b.src  = m_g;
            m_b.last = m_lst;
            m_b.data = m_g ? in1_data : in0_data;
            sbq.push_back(m_b);
            if (m_lst) begin
               m_state = 2'd0;
               m_rr    = !m_g;
            end else if (m_state == 2'd0) begin
               m_state = m_g ? 2'd2 : 2'd1;
            end
         end
         m_ov = m_xf ? 1'b1 : (out_ready ? 1'b0 : m_ov);
      end
   end

   task automatic drive(input logic v0, input logic [W-1:0] d0, input logic l0,
                        input logic v1, input logic [W-1:0] d1, input logic l1,
                        input logic ordy);
      in0_valid = v0; in0_data = d0; in0_last = l0;
      in1_valid = v1; in1_data = d1; in1_last = l1;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   logic [W-1:0] exp_d[6];
   logic         exp_s[6];

   task automatic check_log(input string tag, input int n);
      chk({tag, "_count"}, logq.size(), n);
      for (int i = 0; i < n && i < logq.size(); i++) begin
         chk({tag, "_data"}, logq[i].data, exp_d[i]);
         chk({tag, "_src"},  logq[i].src,  exp_s[i]);
      end
      logq.delete();
   endtask

   initial begin
      in0_valid = 0; in0_data = 0; in0_last = 0;
      in1_valid = 0; in1_data = 0; in1_last = 0;
      out_ready = 1;
      do_reset();
      chk("reset_out_data", out_data, 0);
      chk("reset_out_src", out_src, 0);

      // single-beat packet from source 0
      drive(1, 32'hA5, 1, 0, 0, 0, 1);
      chk("s1_data", out_data, 32'hA5);
      chk("s1_src", out_src, 0);
      chk("s1_valid", out_valid, 1);
      chk("s1_rr", dut.rr_q, 1);
      idle();
      chk("s1_valid_drop", out_valid, 0);
      logq.delete();

      // both sources valid, alternating single beats
      do_reset();
      repeat (4) drive(1, 32'h10, 1, 1, 32'h20, 1, 1);
      idle(); idle();
      exp_d[0] = 32'h10; exp_d[1] = 32'h20; exp_d[2] = 32'h10; exp_d[3] = 32'h20;
      exp_s[0] = 0; exp_s[1] = 1; exp_s[2] = 0; exp_s[3] = 1;
      check_log("s2", 4);

      // 3-beat packet on source 0 with source 1 waiting
      do_reset();
      drive(1, 1, 0, 1, 32'h30, 1, 1);
      drive(1, 2, 0, 1, 32'h30, 1, 1);
      drive(1, 3, 1, 1, 32'h30, 1, 1);
      drive(0, 0, 0, 1, 32'h30, 1, 1);
      idle(); idle();
      exp_d[0] = 1; exp_d[1] = 2; exp_d[2] = 3; exp_d[3] = 32'h30;
      exp_s[0] = 0; exp_s[1] = 0; exp_s[2] = 0; exp_s[3] = 1;
      check_log("s3", 4);

      // backpressure holds 0x55 and loses nothing
      drive(1, 32'h55, 1, 0, 0, 0, 1);
      chk("bp_loaded", out_data, 32'h55);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, 32'h66, 1, 0);
         chk("bp_hold", out_data, 32'h55);
      end
      drive(0, 0, 0, 1, 32'h66, 1, 1);
      chk("bp_reload", out_data, 32'h66);
      idle(); idle();
      exp_d[0] = 32'h55; exp_d[1] = 32'h66;
      exp_s[0] = 0; exp_s[1] = 1;
      check_log("s4", 2);

      // continuous drain-and-load on source 1
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 0, 1, 32'h70 + i, 1, 1);
         chk("nobubble", out_valid, 1);
      end
      idle(); idle();
      for (int i = 0; i < 6; i++) begin
         exp_d[i] = 32'h70 + i;
         exp_s[i] = 1;
      end
      check_log("s5", 6);

      // reset in the middle of a source 1 packet
      do_reset();
      drive(0, 0, 0, 1, 32'hB1, 0, 1);
      drive(0, 0, 0, 1, 32'hB2, 0, 1);
      in0_valid = 1; in0_data = 32'hC1; in0_last = 1;
      in1_valid = 1; in1_data = 32'hB3; in1_last = 0;
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_out_data", out_data, 0);
      chk("rst_mid_out_last", out_last, 0);
      chk("rst_mid_out_src", out_src, 0);
      chk("rst_mid_in0_ready", in0_ready, 0);
      chk("rst_mid_in1_ready", in1_ready, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      logq.delete();
      drive(1, 32'h81, 1, 1, 32'h91, 1, 1);
      drive(1, 32'h81, 1, 1, 32'h91, 1, 1);
      drive(0, 0, 0, 1, 32'h91, 1, 1);
      idle(); idle();
      exp_d[0] = 32'h81; exp_d[1] = 32'h91; exp_d[2] = 32'h91;
      exp_s[0] = 0; exp_s[1] = 1; exp_s[2] = 1;
      check_log("s6", 3);

      for (int i = 0; i < 20 && sbq.size() != 0; i++) idle();
      chk("sb_drained", sbq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
